seq_checker: RTL and testbench



---
 rtl/seq_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_seq_checker.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// seq_checker
//   Receive-side checker for the fixed 7-step sequence stream
//   2, 9, 4, 1, 6, 3, 8, 2, ... It hunts for alignment, verifies
//   LOCK_CNT consecutive in-sequence samples, then monitors the locked
//   stream. Each out-of-sequence sample raises err and is counted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   din_valid  qualifies din; idle cycles change nothing
//   din[3:0]   sample under test
//   locked     high while in LOCKED
//   match      one-cycle pulse: previous valid sample was the expected value
//              (VERIFY or LOCKED)
//   err        one-cycle pulse: previous valid sample mismatched while LOCKED
//   err_count  saturating count of err pulses since reset
//   phase[2:0] index 1..7 of the next expected sample; 0 while hunting
module seq_checker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [3:0]       din,
  output logic             locked,
  output logic             match,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       phase
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Sequence value at table index 1..7; index 0 yields a non-member.
  function automatic logic [3:0] seq_value(input logic [2:0] idx);
    case (idx)
      3'd1:    return 4'h2;
      3'd2:    return 4'h9;
      3'd3:    return 4'h4;
      3'd4:    return 4'h1;
      3'd5:    return 4'h6;
      3'd6:    return 4'h3;
      3'd7:    return 4'h8;
      default: return 4'h0;
    endcase
  endfunction

  // Table index of a sample, 0 when the value is not a sequence member.
  function automatic logic [2:0] seq_index(input logic [3:0] d);
    case (d)
      4'h2:    return 3'd1;
      4'h9:    return 3'd2;
      4'h4:    return 3'd3;
      4'h1:    return 3'd4;
      4'h6:    return 3'd5;
      4'h3:    return 3'd6;
      4'h8:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Successor index with wrap from 7 back to 1.
  function automatic logic [2:0] seq_next(input logic [2:0] idx);
    return (idx == 3'd7) ? 3'd1 : idx + 3'd1;
  endfunction

  state_t             state;
  state_t             nxt_state;
  logic [2:0]         nxt_phase;
  logic [GOOD_W-1:0]  good;
  logic [GOOD_W-1:0]  nxt_good;
  logic [GOOD_W-1:0]  good_inc;
  logic [BAD_W-1:0]   bad;
  logic [BAD_W-1:0]   nxt_bad;
  logic [BAD_W-1:0]   bad_inc;
  logic [2:0]         din_idx;
  logic               hit;
  logic               nxt_locked;
  logic               nxt_match;
  logic               nxt_err;
  logic [ERR_W-1:0]   nxt_err_count;

  assign din_idx  = seq_index(din);
  // phase is never 0 outside HUNT, so hit is only meaningful in VERIFY/LOCKED.
  assign hit      = (din == seq_value(phase));
  assign good_inc = good + GOOD_W'(1);
  assign bad_inc  = bad + BAD_W'(1);

  // State register: FSM state, phase and the lock/unlock run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      phase <= 3'd0;
      good  <= '0;
      bad   <= '0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
      good  <= nxt_good;
      bad   <= nxt_bad;
    end
  end

  // Next-state logic: acquisition, verification and flywheel tracking.
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_good  = good;
    nxt_bad   = bad;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (din_idx != 3'd0) begin
            nxt_phase = seq_next(din_idx);
            nxt_good  = GOOD_W'(1);
            nxt_bad   = '0;
            nxt_state = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end else begin
            nxt_state = HUNT;
          end
        end
        VERIFY: begin
          if (hit) begin
            nxt_phase = seq_next(phase);
            nxt_good  = good_inc;
            if (good_inc >= GOOD_W'(LOCK_CNT)) begin
              nxt_state = LOCKED;
              nxt_bad   = '0;
            end else begin
              nxt_state = VERIFY;
            end
          end else if (din_idx != 3'd0) begin
            // Mismatch re-acquires on this same sample.
            nxt_phase = seq_next(din_idx);
            nxt_good  = GOOD_W'(1);
            nxt_state = VERIFY;
          end else begin
            nxt_phase = 3'd0;
            nxt_good  = '0;
            nxt_state = HUNT;
          end
        end
        LOCKED: begin
          // Phase flywheels through mismatches so a single bad sample
          // does not disturb alignment.
          nxt_phase = seq_next(phase);
          if (hit) begin
            nxt_bad = '0;
          end else if (bad_inc >= BAD_W'(UNLOCK_CNT)) begin
            nxt_state = HUNT;
            nxt_phase = 3'd0;
            nxt_bad   = '0;
            nxt_good  = '0;
          end else begin
            nxt_bad = bad_inc;
          end
        end
        default: begin
          nxt_state = HUNT;
          nxt_phase = 3'd0;
          nxt_good  = '0;
          nxt_bad   = '0;
        end
      endcase
    end else begin
      nxt_state = state;
    end
  end

  // Output logic: next values of the registered pulses and error counter.
  always_comb begin
    nxt_match     = 1'b0;
    nxt_err       = 1'b0;
    nxt_err_count = err_count;
    nxt_locked    = (nxt_state == LOCKED);
    if (din_valid) begin
      case (state)
        VERIFY: begin
          nxt_match = hit;
        end
        LOCKED: begin
          if (hit) begin
            nxt_match = 1'b1;
          end else begin
            nxt_err = 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
              nxt_err_count = err_count + ERR_W'(1);
            end else begin
              nxt_err_count = err_count;
            end
          end
        end
        default: begin
          nxt_match = 1'b0;
        end
      endcase
    end else begin
      nxt_match = 1'b0;
    end
  end

  // Output registers; locked changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      match     <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      locked    <= nxt_locked;
      match     <= nxt_match;
      err       <= nxt_err;
      err_count <= nxt_err_count;
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
module tb_seq_checker;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 2;

  logic       clk;
  logic       rst;
  logic       din_valid;
  logic [3:0] din;
  logic       locked;
  logic       match;
  logic       err;
  logic [7:0] err_count;
  logic [2:0] phase;

  logic       v2;
  logic [3:0] d2;
  logic       locked2;
  logic       match2;
  logic       err2;
  logic [1:0] err_count2;
  logic [2:0] phase2;

  logic [13:0] obs;
  assign obs = {locked, match, err, err_count, phase};

  seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .locked(locked), .match(match), .err(err), .err_count(err_count), .phase(phase)
  );

  seq_checker #(.LOCK_CNT(3), .UNLOCK_CNT(8), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din_valid(v2), .din(d2),
    .locked(locked2), .match(match2), .err(err2), .err_count(err_count2), .phase(phase2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] seq_tab [7];

  // Reference model: mode 0 hunt, 1 verify, 2 locked; m_pos is the
  // 0-based table position of the next expected sample.
  int m_mode;
  int m_pos;
  int m_good;
  int m_bad;
  int m_errs;
  bit e_match;
  bit e_err;
  int gen_pos;

  function automatic int find_pos(input logic [3:0] d);
    for (int i = 0; i < 7; i++) if (seq_tab[i] == d) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_errs = 0;
    e_match = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic [3:0] d);
    int k;
    e_match = 1'b0;
    e_err   = 1'b0;
    if (v) begin
      k = find_pos(d);
      if (m_mode == 0) begin
        if (k >= 0) begin
          m_pos = (k + 1) % 7; m_good = 1; m_bad = 0;
          m_mode = (m_good >= LOCK_CNT) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (d == seq_tab[m_pos]) begin
          e_match = 1'b1; m_pos = (m_pos + 1) % 7; m_good++;
          if (m_good >= LOCK_CNT) begin m_mode = 2; m_bad = 0; end
        end else if (k >= 0) begin
          m_pos = (k + 1) % 7; m_good = 1;
        end else begin
          m_mode = 0; m_good = 0;
        end
      end else begin
        if (d == seq_tab[m_pos]) begin
          e_match = 1'b1; m_bad = 0;
        end else begin
          e_err = 1'b1; m_errs++; m_bad++;
        end
        m_pos = (m_pos + 1) % 7;
        if (m_bad >= UNLOCK_CNT) begin m_mode = 0; m_bad = 0; m_good = 0; end
      end
    end
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [7:0] ec;
    logic [2:0] ph;
    ec = (m_errs > 255) ? 8'd255 : 8'(m_errs);
    ph = (m_mode == 0) ? 3'd0 : 3'(m_pos + 1);
    return {(m_mode == 2), e_match, e_err, ec, ph};
  endfunction

  function automatic logic [3:0] gen_next();
    logic [3:0] s;
    s = seq_tab[gen_pos];
    gen_pos = (gen_pos + 1) % 7;
    return s;
  endfunction

  task automatic drive(input logic v, input logic [3:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    model_step(v, d);
  endtask

  task automatic do_reset();
    din_valid = 1'b0; v2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    gen_pos = 0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs !== 14'd0) $display("FAIL reset_main got %h exp %h", obs, 14'd0);
    else n_pass++;
    n_checks++;
    if ({locked2, match2, err2, err_count2, phase2} !== 8'd0)
      $display("FAIL reset_sat got %h exp %h", {locked2, match2, err2, err_count2, phase2}, 8'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_acquire();
    gen_pos = 0;
    drive(1'b1, 4'h0);
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, gen_next());
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL acquire[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({locked, phase} !== {1'b1, 3'd4}) $display("FAIL acquire_lock got %b exp %b", {locked, phase}, {1'b1, 3'd4});
        else n_pass++;
      end
    end
  endtask

  task automatic test_single_err();
    logic [3:0] skip;
    for (int i = 0; i < 7 && m_pos != 4; i++) drive(1'b1, gen_next());
    skip = gen_next();
    drive(1'b1, 4'h5);
    n_checks++;
    if ({locked, err, err_count} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL single_err got %h exp %h (skipped %h)", {locked, err, err_count}, {1'b1, 1'b1, 8'd1}, skip);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, gen_next());
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL single_err_after[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_double_err();
    logic [3:0] skip;
    for (int i = 0; i < 2; i++) begin
      skip = gen_next();
      drive(1'b1, 4'hF);
    end
    n_checks++;
    if ({locked, err, err_count, phase} !== {1'b0, 1'b1, 8'd3, 3'd0})
      $display("FAIL double_err got %h exp %h", {locked, err, err_count, phase}, {1'b0, 1'b1, 8'd3, 3'd0});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, gen_next());
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL relock[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL relock_locked got %b exp 1", locked);
    else n_pass++;
  endtask

  task automatic test_midstream();
    do_reset();
    gen_pos = 5;
    drive(1'b1, gen_next());
    n_checks++;
    if ({locked, match, phase} !== {1'b0, 1'b0, 3'd7}) $display("FAIL mid_acq got %b exp %b", {locked, match, phase}, {1'b0, 1'b0, 3'd7});
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, gen_next());
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL mid_stream[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL mid_locked got %b exp 1", locked);
    else n_pass++;
    do_reset();
    drive(1'b1, 4'h2);
    drive(1'b1, 4'h9);
    drive(1'b1, 4'h6);
    n_checks++;
    if ({locked, match, err, phase} !== {1'b0, 1'b0, 1'b0, 3'd6})
      $display("FAIL reacquire got %b exp %b", {locked, match, err, phase}, {1'b0, 1'b0, 1'b0, 3'd6});
    else n_pass++;
    n_checks++;
    if (obs !== exp_vec()) $display("FAIL reacquire_model got %h exp %h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_valid_toggle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, gen_next());
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL toggle_valid[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
      drive(1'b0, 4'hF);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL toggle_idle[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [3:0] d;
    int         r;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (!v) d = 4'($urandom_range(0, 15));
      else if (r == 0) d = 4'($urandom_range(0, 15));
      else if (r == 1) begin d = gen_next(); d = gen_next(); end
      else d = gen_next();
      drive(v, d);
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random[%0d] got %h exp %h", i, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] skip;
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, gen_next());
    skip = gen_next();
    drive(1'b1, 4'hA);
    n_checks++;
    if ({locked, err_count} !== {1'b1, 8'd1}) $display("FAIL pre_async got %h exp %h (skipped %h)", {locked, err_count}, {1'b1, 8'd1}, skip);
    else n_pass++;
    din_valid = 1'b1;
    din = gen_next();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({locked, err_count, phase} !== 12'd0) $display("FAIL async_reset got %h exp %h", {locked, err_count, phase}, 12'd0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    int p;
    int exp_ec;
    do_reset();
    p = 0;
    for (int i = 0; i < 3; i++) begin
      v2 = 1'b1; d2 = seq_tab[p]; p = (p + 1) % 7;
      @(posedge clk); #1;
    end
    for (int e = 1; e <= 6; e++) begin
      v2 = 1'b1; d2 = 4'hF; p = (p + 1) % 7;
      @(posedge clk); #1;
      exp_ec = (e > 3) ? 3 : e;
      n_checks++;
      if ({locked2, err2, err_count2} !== {1'b1, 1'b1, 2'(exp_ec)})
        $display("FAIL saturate[%0d] got %b exp %b", e, {locked2, err2, err_count2}, {1'b1, 1'b1, 2'(exp_ec)});
      else n_pass++;
      for (int j = 0; j < 2; j++) begin
        d2 = seq_tab[p]; p = (p + 1) % 7;
        @(posedge clk); #1;
      end
    end
    v2 = 1'b0;
    n_checks++;
    if ({locked2, err_count2} !== {1'b1, 2'd3}) $display("FAIL saturate_hold got %b exp %b", {locked2, err_count2}, {1'b1, 2'd3});
    else n_pass++;
  endtask

  initial begin
    seq_tab = '{4'h2, 4'h9, 4'h4, 4'h1, 4'h6, 4'h3, 4'h8};
    rst = 1'b1; din_valid = 1'b0; din = 4'h0; v2 = 1'b0; d2 = 4'h0;
    gen_pos = 0;
    model_reset();
    test_reset();
    test_acquire();
    test_single_err();
    test_double_err();
    test_midstream();
    test_valid_toggle();
    test_random();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
